mem_wb_writeback: RTL

//   MEM/WB pipeline stage that sits directly upstream of the register file.

---
 rtl/mem_wb_writeback_if.sv | 36 +++
 rtl/mem_wb_writeback.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback_if.sv
// MEM/WB writeback bus: stage controls and MEM-side inputs, register-file and bypass outputs.
// slave is the stage's view; master is the driver/observer (MEM stage plus register file).
interface mem_wb_writeback_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH    = 32
);
    logic                      stall;
    logic                      flush;
    logic                      memValid;
    logic                      memRegWrite;
    logic                      memToReg;
    logic [REG_ADDR_WIDTH-1:0] memRd;
    logic [DATA_WIDTH-1:0]     aluResult;
    logic [DATA_WIDTH-1:0]     memReadData;
    logic [1:0]                loadSize;
    logic                      loadUnsigned;
    logic                      regWrite;
    logic [REG_ADDR_WIDTH-1:0] writeRegister;
    logic [DATA_WIDTH-1:0]     writeData;
    logic                      wbValid;
    logic                      fwdValid;
    logic [COUNT_WIDTH-1:0]    retireCount;

    modport slave (
        input  stall, flush, memValid, memRegWrite, memToReg, memRd,
               aluResult, memReadData, loadSize, loadUnsigned,
        output regWrite, writeRegister, writeData, wbValid, fwdValid, retireCount
    );

    modport master (
        output stall, flush, memValid, memRegWrite, memToReg, memRd,
               aluResult, memReadData, loadSize, loadUnsigned,
        input  regWrite, writeRegister, writeData, wbValid, fwdValid, retireCount
    );
endinterface

// File: rtl/mem_wb_writeback.sv
// MEM/WB stage register feeding the register file: one write per retired instruction, retire counter.
// Optional feature macro LOAD_EXTEND_EN: byte/half lane select with sign/zero extension of load data.
module mem_wb_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic              clock,
    input  logic              resetN,
    mem_wb_writeback_if.slave wb_if
);

    logic                      valid_q,      valid_d;
    logic                      reg_write_q,  reg_write_d;
    logic                      mem_to_reg_q, mem_to_reg_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,         rd_d;
    logic [DATA_WIDTH-1:0]     alu_q,        alu_d;
    logic [DATA_WIDTH-1:0]     rdata_q,      rdata_d;
    logic                      consumed_q,   consumed_d;
    logic [COUNT_WIDTH-1:0]    count_q,      count_d;
    logic                      first_cycle_s;
    logic                      reg_write_s;
    logic [DATA_WIDTH-1:0]     load_data_s;

`ifdef LOAD_EXTEND_EN
    logic [1:0] load_size_q,     load_size_d;
    logic       load_unsigned_q, load_unsigned_d;

    // Lane select and extension; half loads use address bit 1 only, bit 0 is ignored.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            lane,
        input logic [1:0]            size,
        input logic                  uns
    );
        logic [7:0]            byte_v;
        logic [15:0]           half_v;
        logic [DATA_WIDTH-1:0] res_v;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res_v = {{(DATA_WIDTH-8){~uns & byte_v[7]}}, byte_v};
            2'b01:   res_v = {{(DATA_WIDTH-16){~uns & half_v[15]}}, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    assign load_data_s = load_extend(rdata_q, alu_q[1:0], load_size_q, load_unsigned_q);
`else
    logic unused_load_s;

    assign unused_load_s = ^{wb_if.loadSize, wb_if.loadUnsigned};
    assign load_data_s   = rdata_q;
`endif

    assign first_cycle_s = valid_q & ~consumed_q;
    assign reg_write_s   = first_cycle_s & reg_write_q & (rd_q != {REG_ADDR_WIDTH{1'b0}});

    // Next-state for the stage register, the consumed flag and the retire counter.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        rd_d         = rd_q;
        alu_d        = alu_q;
        rdata_d      = rdata_q;
        consumed_d   = consumed_q;
`ifdef LOAD_EXTEND_EN
        load_size_d     = load_size_q;
        load_unsigned_d = load_unsigned_q;
`endif
        // The entry currently held retires in its first cycle, even if the next one is squashed.
        count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, first_cycle_s};
        if (wb_if.flush) begin
            valid_d    = 1'b0;
            consumed_d = 1'b0;
        end else if (wb_if.stall) begin
            consumed_d = consumed_q | valid_q;
        end else begin
            valid_d      = wb_if.memValid;
            reg_write_d  = wb_if.memRegWrite;
            mem_to_reg_d = wb_if.memToReg;
            rd_d         = wb_if.memRd;
            alu_d        = wb_if.aluResult;
            rdata_d      = wb_if.memReadData;
            consumed_d   = 1'b0;
`ifdef LOAD_EXTEND_EN
            load_size_d     = wb_if.loadSize;
            load_unsigned_d = wb_if.loadUnsigned;
`endif
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= {REG_ADDR_WIDTH{1'b0}};
            alu_q        <= {DATA_WIDTH{1'b0}};
            rdata_q      <= {DATA_WIDTH{1'b0}};
            consumed_q   <= 1'b0;
            count_q      <= {COUNT_WIDTH{1'b0}};
`ifdef LOAD_EXTEND_EN
            load_size_q     <= 2'b00;
            load_unsigned_q <= 1'b0;
`endif
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            rd_q         <= rd_d;
            alu_q        <= alu_d;
            rdata_q      <= rdata_d;
            consumed_q   <= consumed_d;
            count_q      <= count_d;
`ifdef LOAD_EXTEND_EN
            load_size_q     <= load_size_d;
            load_unsigned_q <= load_unsigned_d;
`endif
        end
    end

    assign wb_if.regWrite      = reg_write_s;
    assign wb_if.fwdValid      = reg_write_s;
    assign wb_if.wbValid       = valid_q;
    assign wb_if.writeRegister = rd_q;
    assign wb_if.writeData     = mem_to_reg_q ? load_data_s : alu_q;
    assign wb_if.retireCount   = count_q;

endmodule
